// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALT/TRAP FSM.
// Optional macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect TRAP state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        is_halt_word;

    // The memory address comes straight from the PC register.
    assign pc_out       = pc;
    assign pc_plus4     = pc + 32'd4;
    assign is_halt_word = (instr_in == HALT_WORD);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misalign_err = misalign_q;
`else
    logic [1:0] unused_target_lsbs;
    assign unused_target_lsbs = branch_target[1:0];
    assign misalign_err       = 1'b0;
`endif

    // FSM, PC register, IF/ID register and fetch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        // Redirect beats stall and squashes IF/ID.
                        if_id_instr <= 32'd0;
                        if_id_pc4   <= 32'd0;
                        if_id_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (branch_target[1:0] != 2'b00) begin
                            state      <= TRAP;
                            misalign_q <= 1'b1;
                        end else begin
                            pc <= branch_target;
                        end
`else
                        pc <= {branch_target[31:2], 2'b00};
`endif
                    end else begin
                        if (flush) begin
                            if_id_instr <= 32'd0;
                            if_id_pc4   <= 32'd0;
                            if_id_valid <= 1'b0;
                        end else if (!stall) begin
                            if_id_instr <= instr_in;
                            if_id_pc4   <= pc_plus4;
                            if_id_valid <= 1'b1;
                            fetch_count <= fetch_count + 32'd1;
                        end
                        if (!stall) begin
                            // A loaded halt word freezes the PC on itself.
                            if (!flush && is_halt_word) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else begin
                                pc <= pc_plus4;
                            end
                        end
                    end
                end
                HALT, TRAP: begin
                    // Terminal states: only reset leaves them.
                    if_id_instr <= 32'd0;
                    if_id_pc4   <= 32'd0;
                    if_id_valid <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
